uart_burst_mem_ctrl: RTL and testbench

UART_BURST_MEM_CTRL -- requirements
Module: uart_burst_mem_ctrl

---
 rtl/uart_mem_pkg.sv | 21 ++
 rtl/uart_burst_mem_ctrl_if.sv | 22 ++
 rtl/uart_mem_ram.sv | 22 ++
 rtl/uart_burst_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_burst_mem_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_pkg.sv
// Shared constants and state encoding for the UART burst memory controller.
package uart_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h02;
  localparam logic [BYTE_W-1:0] ACK_CODE  = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_LEN,
    WR_DATA,
    RD_FETCH,
    RD_SEND,
    RD_WAIT,
    ACK
  } state_t;

endpackage

// File: rtl/uart_burst_mem_ctrl_if.sv
// UART-side byte stream bundle: receive strobe/byte in, transmit request/byte out.
interface uart_burst_mem_ctrl_if;

  logic       received;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       err;
  logic       busy;

  modport master (
    output received, rx_byte, tx_busy,
    input  transmit, tx_byte, err, busy
  );

  modport slave (
    input  received, rx_byte, tx_busy,
    output transmit, tx_byte, err, busy
  );

endinterface

// File: rtl/uart_mem_ram.sv
// DEPTH x 8 single-clock memory: synchronous write, registered read.
module uart_mem_ram #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/uart_burst_mem_ctrl.sv
// Command-framed burst read/write access to a local RAM over a UART byte stream.
// Define UART_MEM_TIMEOUT_EN to abort half-received frames after TIMEOUT_CYCLES of silence.
module uart_burst_mem_ctrl
  import uart_mem_pkg::*;
#(
  parameter int unsigned ADDR_BYTES     = 1,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_burst_mem_ctrl_if.slave  uart_if
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    len_q, len_d;
  logic          is_read_q, is_read_d;
  logic          transmit_q, transmit_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          err_q, err_d;
  logic          busy_q;
  logic          err_req;
  logic          mem_we;
  logic [7:0]    rdata;
  logic          timeout_c;

`ifdef UART_MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Silence counter, live only while a frame is partially received.
  always_comb begin
    tmo_d     = '0;
    timeout_c = 1'b0;
    if ((state_q inside {RX_ADDR, RX_LEN, WR_DATA}) && !uart_if.received) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_c = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    is_read_d  = is_read_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    err_req    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (uart_if.received) begin
          if (uart_if.rx_byte == CMD_READ || uart_if.rx_byte == CMD_WRITE) begin
            is_read_d = (uart_if.rx_byte == CMD_READ);
            addr_d    = '0;
            cnt_d     = '0;
            state_d   = RX_ADDR;
          end else begin
            err_req = 1'b1;
          end
        end
      end
      RX_ADDR: begin
        // Shifting MSB-first into an AW-bit register applies the modulo for free.
        if (uart_if.received) begin
          addr_d = AW'({addr_q, uart_if.rx_byte});
          if (cnt_q == 8'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = RX_LEN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      RX_LEN: begin
        if (uart_if.received) begin
          len_d   = uart_if.rx_byte;
          cnt_d   = '0;
          state_d = is_read_q ? RD_FETCH : WR_DATA;
        end
      end
      WR_DATA: begin
        if (uart_if.received) begin
          mem_we = 1'b1;
          addr_d = addr_q + AW'(1);
          if (cnt_q == len_q) begin
            state_d = ACK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      RD_FETCH: begin
        err_req = uart_if.received;
        state_d = RD_SEND;
      end
      RD_SEND: begin
        err_req = uart_if.received;
        if (!uart_if.tx_busy) begin
          transmit_d = 1'b1;
          tx_byte_d  = rdata;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // The UART raises tx_busy one cycle after the strobe, so that cycle is skipped.
        err_req = uart_if.received;
        if (!transmit_q && !uart_if.tx_busy) begin
          addr_d = addr_q + AW'(1);
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = RD_FETCH;
          end
        end
      end
      ACK: begin
        err_req = uart_if.received;
        if (!uart_if.tx_busy) begin
          transmit_d = 1'b1;
          tx_byte_d  = ACK_CODE;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_c) begin
      err_req = 1'b1;
      state_d = IDLE;
    end

    err_d = err_req && !err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      is_read_q  <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      is_read_q  <= is_read_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      err_q      <= err_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  uart_mem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (uart_if.rx_byte),
    .raddr_i (addr_q),
    .rdata_o (rdata)
  );

  assign uart_if.transmit = transmit_q;
  assign uart_if.tx_byte  = tx_byte_q;
  assign uart_if.err      = err_q;
  assign uart_if.busy     = busy_q;

endmodule

// File: tb/tb_uart_burst_mem_ctrl.sv
// Bench for uart_burst_mem_ctrl: frame-level memory model plus expected-response queue.
module tb_uart_burst_mem_ctrl;
  import uart_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rcv;
  logic [7:0] rxb;
  logic       tx_busy = 1'b0;
  int         sel = 0;

  always #5 clk = ~clk;

  uart_burst_mem_ctrl_if if0 ();
  uart_burst_mem_ctrl_if if1 ();

  assign if0.received = rcv && (sel == 0);
  assign if0.rx_byte  = rxb;
  assign if0.tx_busy  = tx_busy;
  assign if1.received = rcv && (sel == 1);
  assign if1.rx_byte  = rxb;
  assign if1.tx_busy  = tx_busy;

  uart_burst_mem_ctrl #(.ADDR_BYTES(1), .DEPTH(256), .TIMEOUT_CYCLES(300)) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_if(if0.slave));
  uart_burst_mem_ctrl #(.ADDR_BYTES(2), .DEPTH(1024), .TIMEOUT_CYCLES(300)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_if(if1.slave));

  logic       t_s, e_s, b_s;
  logic [7:0] tb_s;
  assign t_s  = (sel == 1) ? if1.transmit : if0.transmit;
  assign e_s  = (sel == 1) ? if1.err      : if0.err;
  assign b_s  = (sel == 1) ? if1.busy     : if0.busy;
  assign tb_s = (sel == 1) ? if1.tx_byte  : if0.tx_byte;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] m0 [256];
  logic [7:0] m1 [1024];
  logic [7:0] exp_q [$];
  logic [7:0] log_q [$];
  logic [7:0] dbuf [16];
  int         err_seen = 0;
  int         err_exp = 0;
  int         busy_len = 0;
  int         busy_cnt = 0;
  logic       pt = 1'b0;
  logic       pe = 1'b0;
  logic       bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int nab();
    return (sel == 1) ? 2 : 1;
  endfunction

  task automatic mwrite(input int a, input logic [7:0] d);
    if (sel == 1) m1[a % 1024] = d;
    else          m0[a % 256]  = d;
  endtask

  function automatic logic [7:0] mread(input int a);
    return (sel == 1) ? m1[a % 1024] : m0[a % 256];
  endfunction

  // Compare process: checks every strobe against the expected queue and emulates the UART's tx_busy.
  initial begin
    forever begin
      @(negedge clk);
      if (t_s) begin
        chk("tx_while_busy", 32'(tx_busy), 0);
        chk("tx_back_to_back", 32'(pt), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: got %0h expected no strobe", tb_s);
        end else begin
          chk("tx_byte", 32'(tb_s), 32'(exp_q.pop_front()));
        end
        log_q.push_back(tb_s);
      end
      if (e_s) begin
        err_seen++;
        chk("err_back_to_back", 32'(pe), 0);
      end
      pt = t_s;
      pe = e_s;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (t_s && busy_len > 0) begin
        tx_busy  = 1'b1;
        busy_cnt = busy_len;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxb = b;
    rcv = 1'b1;
    @(negedge clk);
    rcv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input int addr, input int n);
    send_byte(cmd);
    for (int k = 0; k < nab(); k++) send_byte(8'(addr >> (8 * (nab() - 1 - k))));
    send_byte(8'(n - 1));
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || b_s || tx_busy) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, 32'(k < 5000), 1);
    chk({name, "_err_count"}, 32'(err_seen), 32'(err_exp));
  endtask

  task automatic do_write(input int addr, input int n);
    exp_q.push_back(ACK_CODE);
    for (int i = 0; i < n; i++) mwrite(addr + i, dbuf[i]);
    send_hdr(CMD_WRITE, addr, n);
    for (int i = 0; i < n; i++) send_byte(dbuf[i]);
    wait_done("write");
  endtask

  task automatic start_read(input int addr, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mread(addr + i));
    send_hdr(CMD_READ, addr, n);
  endtask

  task automatic do_read(input int addr, input int n);
    start_read(addr, n);
    wait_done("read");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rcv   = 1'b0;
    rxb   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_transmit", 32'(if0.transmit), 0);
    chk("rst_tx_byte", 32'(if0.tx_byte), 0);
    chk("rst_err", 32'(if0.err), 0);
    chk("rst_busy", 32'(if0.busy), 0);
    chk("rst_busy1", 32'(if1.busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write then read back.
    log_q.delete();
    dbuf[0] = 8'h5A;
    do_write(32'h10, 1);
    chk("ack_byte", 32'(log_q[0]), 32'hAA);
    log_q.delete();
    do_read(32'h10, 1);
    chk("rd_single_n", 32'(log_q.size()), 1);
    chk("rd_single", 32'(log_q[0]), 32'h5A);

    // Burst crossing the top of memory.
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
    do_write(32'hFE, 3);
    log_q.delete();
    do_read(32'hFE, 3);
    chk("wrap_rd0", 32'(log_q[0]), 32'h11);
    chk("wrap_rd1", 32'(log_q[1]), 32'h22);
    chk("wrap_rd2", 32'(log_q[2]), 32'h33);
    log_q.delete();
    do_read(32'h00, 1);
    chk("wrap_mem00", 32'(log_q[0]), 32'h33);

    // Slow transmitter.
    busy_len = 50;
    dbuf[0] = 8'hA1; dbuf[1] = 8'hA2; dbuf[2] = 8'hA3; dbuf[3] = 8'hA4;
    do_write(32'h40, 4);
    log_q.delete();
    do_read(32'h40, 4);
    chk("flow_strobes", 32'(log_q.size()), 4);
    chk("flow_last", 32'(log_q[3]), 32'hA4);

    // Stray byte while a read burst is running.
    busy_len = 20;
    log_q.delete();
    start_read(32'h40, 4);
    repeat (15) @(negedge clk);
    send_byte(8'h55);
    err_exp++;
    wait_done("stray");
    chk("stray_strobes", 32'(log_q.size()), 4);

    // Unknown command.
    busy_len = 0;
    bad = 1'b0;
    send_byte(8'h07);
    err_exp++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if0.busy) bad = 1'b1;
    end
    chk("bad_busy", 32'(bad), 0);
    chk("bad_err", 32'(err_seen), 32'(err_exp));
    dbuf[0] = 8'h3C; dbuf[1] = 8'hC3;
    do_write(32'h80, 2);
    log_q.delete();
    do_read(32'h80, 2);
    chk("bad_then_rd", 32'(log_q[1]), 32'hC3);

    // Silence after a command byte.
    send_byte(CMD_WRITE);
    repeat (350) @(negedge clk);
`ifdef UART_MEM_TIMEOUT_EN
    err_exp++;
    chk("tmo_busy", 32'(if0.busy), 0);
    chk("tmo_err", 32'(err_seen), 32'(err_exp));
`else
    chk("notmo_busy", 32'(if0.busy), 1);
    exp_q.push_back(ACK_CODE);
    mwrite(32'h30, 8'hC3);
    send_byte(8'h30);
    send_byte(8'h00);
    send_byte(8'hC3);
    wait_done("notmo");
`endif

    // Reset in the middle of a read burst.
    busy_len = 20;
    for (int i = 0; i < 8; i++) dbuf[i] = 8'(8'h60 + i);
    do_write(32'h50, 8);
    start_read(32'h50, 8);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_transmit", 32'(if0.transmit), 0);
    chk("midrst_busy", 32'(if0.busy), 0);
    chk("midrst_tx_byte", 32'(if0.tx_byte), 0);
    repeat (30) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    busy_len = 0;
    log_q.delete();
    do_read(32'h50, 8);
    chk("midrst_mem_kept", 32'(log_q[7]), 32'h67);

    // Two address bytes, 1024-word memory.
    sel = 1;
    repeat (2) @(negedge clk);
    dbuf[0] = 8'h77;
    do_write(32'h3FF, 1);
    dbuf[0] = 8'h88;
    do_write(32'h7FF, 1);
    log_q.delete();
    do_read(32'h3FF, 1);
    chk("mod_rd", 32'(log_q[0]), 32'h88);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
